multi_fuser: RTL and testbench

MULTI_FUSER -- requirements
Module: multi_fuser

---
 rtl/multi_fuser_pkg.sv | 34 +++
 rtl/multi_fuser_chunk_majority.sv | 59 +++++
 rtl/multi_fuser.sv | 136 +++++++++++++
 tb/tb_multi_fuser.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/multi_fuser_pkg.sv
// multi_fuser_pkg: shared constants for the hypervector fuser.
// Provides HV_DIMENSION / ceilLog2 fallbacks when no project const.vh is
// present, the FSM state encodings and helpers that derive chunk count and
// counter widths. Optional feature macro used by the fuser: FUSER_TIEBREAK_EN.
`ifndef HV_DIMENSION
`define HV_DIMENSION 64
`endif
`ifndef ceilLog2
`define ceilLog2(x) ($clog2(x))
`endif

package multi_fuser_pkg;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  // Number of chunk passes needed to cover one hypervector
  function automatic int fuser_num_chunks(input int dim, input int chunk_width);
    return dim / chunk_width;
  endfunction

  // Width of the chunk index counter (at least one bit)
  function automatic int fuser_cnt_width(input int num_chunks);
    return (num_chunks > 1) ? $clog2(num_chunks) : 1;
  endfunction

  // Width of a per-bit ones count; NUM_MOD itself must be representable
  function automatic int fuser_count_width(input int num_mod);
    return `ceilLog2(num_mod) + 1;
  endfunction

endpackage

// File: rtl/multi_fuser_chunk_majority.sv
// fuser_chunk_majority: combinational bitwise majority over NUM_MOD channels
// of one CHUNK_WIDTH-bit chunk. Channel m occupies chunk_in[m*CHUNK_WIDTH +: CHUNK_WIDTH].
// With FUSER_TIEBREAK_EN defined, an exact tie (even NUM_MOD) takes channel 0's
// bit; otherwise a tie resolves to 0.
module fuser_chunk_majority
  import multi_fuser_pkg::*;
#(
  parameter int NUM_MOD     = 3,
  parameter int CHUNK_WIDTH = 16
) (
  input  logic [NUM_MOD*CHUNK_WIDTH-1:0] chunk_in,
  output logic [CHUNK_WIDTH-1:0]         maj_out
);

  localparam int              CNT_W   = fuser_count_width(NUM_MOD);
  localparam logic [CNT_W-1:0] HALF   = CNT_W'(NUM_MOD / 2);
  localparam bit              IS_EVEN = ((NUM_MOD % 2) == 0);
`ifdef FUSER_TIEBREAK_EN
  localparam bit              TIE_TO_CH0 = 1'b1;
`else
  localparam bit              TIE_TO_CH0 = 1'b0;
`endif

  // Population count of one bit column, zero-extending each input bit
  function automatic logic [CNT_W-1:0] count_ones(input logic [NUM_MOD-1:0] bits);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int m = 0; m < NUM_MOD; m++) begin
      acc = acc + CNT_W'(bits[m]);
    end
    return acc;
  endfunction

  for (genvar b = 0; b < CHUNK_WIDTH; b++) begin : g_bit
    logic [NUM_MOD-1:0] column;
    logic [CNT_W-1:0]   ones;
    logic               bit_out;

    for (genvar m = 0; m < NUM_MOD; m++) begin : g_col
      assign column[m] = chunk_in[m*CHUNK_WIDTH + b];
    end

    assign ones = count_ones(column);

    // Strict majority wins; an exact tie only exists for even channel counts
    always_comb begin
      if (ones > HALF) begin
        bit_out = 1'b1;
      end else if (IS_EVEN && (ones == HALF)) begin
        bit_out = TIE_TO_CH0 ? column[0] : 1'b0;
      end else begin
        bit_out = 1'b0;
      end
    end

    assign maj_out[b] = bit_out;
  end

endmodule

// File: rtl/multi_fuser.sv
// multi_fuser: bundles NUM_MOD hypervectors by bitwise majority, one
// CHUNK_WIDTH slice per cycle. Inputs are not buffered: the source holds hvin
// until the single-cycle hvin_ready strobe on the last chunk. The result is
// held with hvout_valid until hvout_ready. Optional macro: FUSER_TIEBREAK_EN
// (ties on even NUM_MOD follow channel 0 instead of resolving to 0).
module multi_fuser
  import multi_fuser_pkg::*;
#(
  parameter int NUM_MOD     = 3,
  parameter int CHUNK_WIDTH = `HV_DIMENSION / 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_MOD-1:0]               hvin_valid,
  input  logic [NUM_MOD*`HV_DIMENSION-1:0] hvin,
  output logic                             hvin_ready,
  output logic                             hvout_valid,
  input  logic                             hvout_ready,
  output logic [`HV_DIMENSION-1:0]         hvout
);

  localparam int               HV         = `HV_DIMENSION;
  localparam int               NUM_CHUNKS = fuser_num_chunks(HV, CHUNK_WIDTH);
  localparam int               CNT_W      = fuser_cnt_width(NUM_CHUNKS);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  logic [1:0]                   state_r;
  logic [1:0]                   state_next;
  logic [CNT_W-1:0]             chunk_r;
  logic [CNT_W-1:0]             chunk_next;
  logic                         ready_r;
  logic                         ready_next;
  logic                         valid_r;
  logic                         valid_next;
  logic [HV-1:0]                hvout_r;
  logic [31:0]                  chunk_base;
  logic [NUM_MOD*CHUNK_WIDTH-1:0] chunk_bits;
  logic [CHUNK_WIDTH-1:0]       chunk_maj;
  logic                         all_valid;

  assign all_valid  = &hvin_valid;
  assign chunk_base = 32'(chunk_r) * 32'(CHUNK_WIDTH);

  // Gather the current chunk of every channel straight from the held input
  for (genvar m = 0; m < NUM_MOD; m++) begin : g_sel
    assign chunk_bits[m*CHUNK_WIDTH +: CHUNK_WIDTH] = hvin[m*HV + chunk_base +: CHUNK_WIDTH];
  end

  fuser_chunk_majority #(
    .NUM_MOD     (NUM_MOD),
    .CHUNK_WIDTH (CHUNK_WIDTH)
  ) u_majority (
    .chunk_in (chunk_bits),
    .maj_out  (chunk_maj)
  );

  // Next-state logic: accept only on a full valid set, walk the chunks, then hold
  always_comb begin
    state_next = state_r;
    chunk_next = chunk_r;
    valid_next = valid_r;
    case (state_r)
      ST_IDLE: begin
        if (all_valid) begin
          state_next = ST_ACCUM;
          chunk_next = '0;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        // Valid drops in this state are deliberately ignored
        if (chunk_r == LAST_CHUNK) begin
          state_next = ST_HOLD;
          chunk_next = '0;
          valid_next = 1'b1;
        end else begin
          chunk_next = chunk_r + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (hvout_ready) begin
          state_next = ST_IDLE;
          valid_next = 1'b0;
        end else begin
          state_next = ST_HOLD;
        end
      end
      default: begin
        state_next = ST_IDLE;
        chunk_next = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  // The consume strobe is registered: raise it for the cycle that works on the last chunk
  always_comb begin
    if ((state_next == ST_ACCUM) && (chunk_next == LAST_CHUNK)) begin
      ready_next = 1'b1;
    end else begin
      ready_next = 1'b0;
    end
  end

  // Control registers; reset abandons any in-flight operation immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      chunk_r <= '0;
      ready_r <= 1'b0;
      valid_r <= 1'b0;
    end else begin
      state_r <= state_next;
      chunk_r <= chunk_next;
      ready_r <= ready_next;
      valid_r <= valid_next;
    end
  end

  // Result register: one chunk written per ACCUM cycle, other chunks keep their old value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hvout_r <= '0;
    end else if (state_r == ST_ACCUM) begin
      hvout_r[chunk_base +: CHUNK_WIDTH] <= chunk_maj;
    end else begin
      hvout_r <= hvout_r;
    end
  end

  assign hvin_ready  = ready_r;
  assign hvout_valid = valid_r;
  assign hvout       = hvout_r;

endmodule

// File: tb/tb_multi_fuser.sv
// tb_multi_fuser: directed checks of multi_fuser with NUM_MOD = 3, 4 and 8
// instances sharing clock and reset; expected values are hand-computed.
module tb_multi_fuser;

  localparam int HV = `HV_DIMENSION;

  logic clk;
  logic rst_n;

  logic [2:0]      v3;
  logic [3*HV-1:0] in3;
  logic            rdy3;
  logic            ov3;
  logic            ordy3;
  logic [HV-1:0]   out3;

  logic [3:0]      v4;
  logic [4*HV-1:0] in4;
  logic            rdy4;
  logic            ov4;
  logic            ordy4;
  logic [HV-1:0]   out4;

  logic [7:0]      v8;
  logic [8*HV-1:0] in8;
  logic            rdy8;
  logic            ov8;
  logic            ordy8;
  logic [HV-1:0]   out8;

  int tests;
  int failed;
  int pulses;

  logic [63:0] pat_a;
  logic [63:0] pat_p;
  logic [63:0] exp4;
  logic [63:0] exp8;

  multi_fuser #(.NUM_MOD(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .hvin_valid(v3), .hvin(in3), .hvin_ready(rdy3),
    .hvout_valid(ov3), .hvout_ready(ordy3), .hvout(out3)
  );

  multi_fuser #(.NUM_MOD(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hvin_valid(v4), .hvin(in4), .hvin_ready(rdy4),
    .hvout_valid(ov4), .hvout_ready(ordy4), .hvout(out4)
  );

  multi_fuser #(.NUM_MOD(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .hvin_valid(v8), .hvin(in8), .hvin_ready(rdy8),
    .hvout_valid(ov8), .hvout_ready(ordy8), .hvout(out8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  initial begin
    tests  = 0;
    failed = 0;
    pulses = 0;
    pat_a  = 64'hAAAA_AAAA_AAAA_AAAA;
    pat_p  = 64'h0123_4567_89AB_CDEF;
    rst_n  = 1'b0;
    v3 = 3'b000; in3 = '0; ordy3 = 1'b0;
    v4 = 4'b0000; in4 = '0; ordy4 = 1'b0;
    v8 = 8'h00; in8 = '0; ordy8 = 1'b0;

    // Reset state
    #3;
    chk("rst_hvout", out3, 64'd0);
    chk("rst_valid", 64'(ov3), 64'd0);
    chk("rst_ready", 64'(rdy3), 64'd0);
    #20;
    rst_n = 1'b1;

    // ones/ones/zeros -> all ones, latency 4, one ready pulse; valid drop ignored
    in3 = {64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    v3  = 3'b111;
    for (int i = 0; i <= 4; i++) begin
      tick();
      if (i == 0) v3 = 3'b000;
      if (rdy3) pulses++;
      chk($sformatf("s1_ready_c%0d", i), 64'(rdy3), 64'(i == 3));
      chk($sformatf("s1_valid_c%0d", i), 64'(ov3), 64'(i == 4));
    end
    chk("s1_pulses", 64'(pulses), 64'd1);
    chk("s1_hvout", out3, 64'hFFFF_FFFF_FFFF_FFFF);
    ordy3 = 1'b1;
    tick();
    ordy3 = 1'b0;
    chk("s1_exit_valid", 64'(ov3), 64'd0);
    chk("s1_retain", out3, 64'hFFFF_FFFF_FFFF_FFFF);

    // Partial valid keeps the FSM idle; full set starts on the next edge
    in3 = {64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0, pat_a};
    v3  = 3'b011;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("s2_idle_ready_%0d", i), 64'(rdy3), 64'd0);
      chk($sformatf("s2_idle_valid_%0d", i), 64'(ov3), 64'd0);
    end
    chk("s2_idle_hvout", out3, 64'hFFFF_FFFF_FFFF_FFFF);
    v3 = 3'b111;
    tick();
    tick();
    tick();
    tick();
    chk("s2_valid_before", 64'(ov3), 64'd0);
    tick();
    chk("s2_valid_after", 64'(ov3), 64'd1);
    chk("s2_hvout", out3, pat_a);

    // Backpressure in HOLD: output stable, no further consume strobe
    for (int i = 0; i < 20; i++) begin
      tick();
      chk($sformatf("s3_valid_%0d", i), 64'(ov3), 64'd1);
      chk($sformatf("s3_hvout_%0d", i), out3, pat_a);
      chk($sformatf("s3_ready_%0d", i), 64'(rdy3), 64'd0);
    end
    v3    = 3'b000;
    ordy3 = 1'b1;
    tick();
    ordy3 = 1'b0;
    chk("s3_exit_valid", 64'(ov3), 64'd0);

    // Asynchronous reset during chunk 2, then a fresh operation
    in3 = {~pat_p, pat_p, pat_p};
    v3  = 3'b111;
    tick();
    tick();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    chk("s4_rst_hvout", out3, 64'd0);
    chk("s4_rst_valid", 64'(ov3), 64'd0);
    chk("s4_rst_ready", 64'(rdy3), 64'd0);
    #1;
    rst_n = 1'b1;
    tick();
    pulses = 0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (rdy3) pulses++;
    end
    chk("s4_pulses", 64'(pulses), 64'd1);
    chk("s4_valid", 64'(ov3), 64'd1);
    chk("s4_hvout", out3, pat_p);
    v3    = 3'b000;
    ordy3 = 1'b1;
    tick();
    ordy3 = 1'b0;

    // NUM_MOD=4 full tie on every bit
`ifdef FUSER_TIEBREAK_EN
    exp4 = pat_a;
`else
    exp4 = 64'd0;
`endif
    in4 = {~pat_a, pat_a, ~pat_a, pat_a};
    v4  = 4'b1111;
    for (int i = 0; i <= 4; i++) tick();
    v4 = 4'b0000;
    chk("s5_valid", 64'(ov4), 64'd1);
    chk("s5_hvout", out4, exp4);

    // NUM_MOD=8: bit0 5 ones, bit1 4 ones (ch0 set), bit2 8 ones, bit62 5 ones, bit63 3 ones
    for (int m = 0; m < 8; m++) begin
      logic [63:0] ch;
      ch     = 64'd0;
      ch[0]  = (m < 5);
      ch[1]  = (m < 4);
      ch[2]  = 1'b1;
      ch[62] = (m >= 3);
      ch[63] = (m < 3);
      in8[m*HV +: HV] = ch;
    end
`ifdef FUSER_TIEBREAK_EN
    exp8 = 64'h4000_0000_0000_0007;
`else
    exp8 = 64'h4000_0000_0000_0005;
`endif
    v8 = 8'hFF;
    for (int i = 0; i <= 4; i++) tick();
    v8 = 8'h00;
    chk("s6_valid", 64'(ov8), 64'd1);
    chk("s6_hvout", out8, exp8);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
